// File: rtl/blinky_ctrl.sv
// blinky_ctrl: LED pattern sequencer (solid, continuous blink, burst).
// New configurations land in a shadow register and are applied only at
// phase boundaries, so an in-flight blink is never cut short.

package blinky_pkg;
  localparam int CounterWidth = 4;
  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_BURST = 2'd3
  } mode_e;
endpackage

// state | meaning
// ------+----------------------------------------------------------
// IDLE  | LED off, disabled or active mode OFF
// SOLID | LED on continuously (mode ON)
// HI    | LED on for one period of P cycles
// LO    | LED off for one period of P cycles
// GAP   | LED off between bursts, GapTicks periods
module blinky_ctrl #(
  parameter int CounterWidth  = blinky_pkg::CounterWidth,
  parameter int PrescaleWidth = 16,
  parameter int GapTicks      = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     enable_i,
  input  logic                     cfg_valid_i,
  output logic                     cfg_ready_o,
  input  logic [1:0]               cfg_mode_i,
  input  logic [PrescaleWidth-1:0] cfg_period_i,
  input  logic [CounterWidth-1:0]  cfg_count_i,
  output logic                     led_o,
  output logic                     busy_o,
  output logic                     burst_done_o
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SOLID = 3'd1,
    ST_HI    = 3'd2,
    ST_LO    = 3'd3,
    ST_GAP   = 3'd4
  } state_e;

  state_e                   state_q;
  blinky_pkg::mode_e        mode_q, shd_mode_q;
  logic [PrescaleWidth-1:0] period_q, shd_period_q, presc_q;
  logic [CounterWidth-1:0]  count_q, shd_count_q, blink_q, gap_q;
  logic                     pending_q, burst_done_q;

  logic [PrescaleWidth-1:0] period_last;
  logic [CounterWidth-1:0]  count_last;
  logic [CounterWidth-1:0]  gap_last;
  logic                     running, tick, boundary, apply, accept;

  // A zero period or count behaves as one, so the last index is 0 in both cases.
  assign period_last = (period_q == '0) ? '0 : period_q - PrescaleWidth'(1);
  assign count_last  = (count_q == '0) ? '0 : count_q - CounterWidth'(1);
  assign gap_last    = CounterWidth'(GapTicks - 1);

  assign running  = (state_q == ST_HI) || (state_q == ST_LO) || (state_q == ST_GAP);
  assign tick     = running && (presc_q == period_last);
  // HI is not a boundary: switching there would truncate the lit half of a blink.
  assign boundary = (state_q == ST_IDLE) || (state_q == ST_SOLID) ||
                    (tick && ((state_q == ST_LO) || (state_q == ST_GAP)));
  assign apply    = pending_q && boundary;
  assign accept   = cfg_valid_i && !pending_q;

  function automatic state_e start_state(input blinky_pkg::mode_e m);
    case (m)
      blinky_pkg::MODE_OFF: return ST_IDLE;
      blinky_pkg::MODE_ON:  return ST_SOLID;
      default:              return ST_HI;
    endcase
  endfunction

  // Handshake, shadow/active config, prescaler, counters and FSM state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      mode_q       <= blinky_pkg::MODE_OFF;
      period_q     <= '0;
      count_q      <= '0;
      shd_mode_q   <= blinky_pkg::MODE_OFF;
      shd_period_q <= '0;
      shd_count_q  <= '0;
      pending_q    <= 1'b0;
      presc_q      <= '0;
      blink_q      <= '0;
      gap_q        <= '0;
      burst_done_q <= 1'b0;
    end else begin
      burst_done_q <= 1'b0;
      if (accept) begin
        shd_mode_q   <= blinky_pkg::mode_e'(cfg_mode_i);
        shd_period_q <= cfg_period_i;
        shd_count_q  <= cfg_count_i;
        pending_q    <= 1'b1;
      end
      if (apply) begin
        mode_q    <= shd_mode_q;
        period_q  <= shd_period_q;
        count_q   <= shd_count_q;
        pending_q <= 1'b0;
        presc_q   <= '0;
        blink_q   <= '0;
        gap_q     <= '0;
        state_q   <= enable_i ? start_state(shd_mode_q) : ST_IDLE;
      end else if (!enable_i) begin
        state_q <= ST_IDLE;
        presc_q <= '0;
        blink_q <= '0;
        gap_q   <= '0;
      end else begin
        if (running) presc_q <= tick ? '0 : presc_q + PrescaleWidth'(1);
        case (state_q)
          ST_IDLE:  if (mode_q != blinky_pkg::MODE_OFF) state_q <= start_state(mode_q);
          ST_SOLID: state_q <= ST_SOLID;
          ST_HI:    if (tick) state_q <= ST_LO;
          ST_LO: begin
            if (tick) begin
              if (mode_q == blinky_pkg::MODE_BURST && blink_q == count_last) begin
                blink_q      <= '0;
                burst_done_q <= 1'b1;
                state_q      <= ST_GAP;
              end else begin
                if (mode_q == blinky_pkg::MODE_BURST) blink_q <= blink_q + CounterWidth'(1);
                state_q <= ST_HI;
              end
            end
          end
          ST_GAP: begin
            if (tick) begin
              if (gap_q == gap_last) begin
                gap_q   <= '0;
                state_q <= ST_HI;
              end else begin
                gap_q <= gap_q + CounterWidth'(1);
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign cfg_ready_o  = !pending_q;
  assign led_o        = (state_q == ST_SOLID) || (state_q == ST_HI);
  assign busy_o       = (state_q != ST_IDLE) || pending_q;
  assign burst_done_o = burst_done_q;

endmodule

// File: tb/tb_blinky_ctrl.sv
// Directed bench for blinky_ctrl: a per-cycle vector table plus hand-written
// sequences for deferred apply, reset mid-blink, burst shape and enable drop.
module tb_blinky_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        valid = 1'b0;
  logic        ready;
  logic [1:0]  mode = 2'd0;
  logic [15:0] period = 16'd0;
  logic [3:0]  count = 4'd0;
  logic        led, busy, done;

  int checks = 0;
  int errors = 0;

  blinky_ctrl #(.CounterWidth(4), .PrescaleWidth(16), .GapTicks(8)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .enable_i     (en),
    .cfg_valid_i  (valid),
    .cfg_ready_o  (ready),
    .cfg_mode_i   (mode),
    .cfg_period_i (period),
    .cfg_count_i  (count),
    .led_o        (led),
    .busy_o       (busy),
    .burst_done_o (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        valid;
    logic [1:0]  mode;
    logic [15:0] period;
    logic [3:0]  count;
    logic        led;
    logic        rdy;
    logic        busy;
  } vec_t;

  vec_t vecs [30];

  function automatic vec_t mkv(input logic e, input logic vl, input logic [1:0] m,
                               input logic [15:0] p, input logic [3:0] c,
                               input logic l, input logic r, input logic b);
    vec_t x;
    x.en = e; x.valid = vl; x.mode = m; x.period = p; x.count = c;
    x.led = l; x.rdy = r; x.busy = b;
    return x;
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    valid = 1'b0;
    en    = 1'b0;
    #1;
    chk("reset led", led, 1'b0);
    chk("reset ready", ready, 1'b1);
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Returns at the negedge of the first cycle in the new mode's start state.
  task automatic start_cfg(input logic [1:0] m, input logic [15:0] p, input logic [3:0] c);
    @(negedge clk);
    en = 1'b1; valid = 1'b1; mode = m; period = p; count = c;
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_burst(input int p, input int n, input int cycles);
    int pp, nn, len, on_len, pos;
    pp = (p == 0) ? 1 : p;
    nn = (n == 0) ? 1 : n;
    on_len = nn * 2 * pp;
    len = on_len + 8 * pp;
    for (int k = 0; k < cycles; k++) begin
      pos = k % len;
      chk($sformatf("burst p%0d n%0d led k%0d", p, n, k), led,
          (pos < on_len) && ((pos % (2 * pp)) < pp));
      chk($sformatf("burst p%0d n%0d done k%0d", p, n, k), done, pos == on_len);
      @(negedge clk);
    end
  endtask

  initial begin
    //           en v  mode per cnt  led rdy busy
    vecs[0]  = mkv(1, 1, 2'd1, 16'd0, 4'd0, 0, 1, 0);
    vecs[1]  = mkv(1, 0, 2'd0, 16'd0, 4'd0, 0, 0, 1);
    vecs[2]  = mkv(1, 0, 2'd0, 16'd0, 4'd0, 1, 1, 1);
    vecs[3]  = mkv(1, 1, 2'd2, 16'd3, 4'd0, 1, 1, 1);
    vecs[4]  = mkv(1, 0, 2'd0, 16'd0, 4'd0, 1, 0, 1);
    vecs[5]  = mkv(1, 0, 2'd0, 16'd0, 4'd0, 1, 1, 1);
    vecs[6]  = mkv(1, 0, 2'd0, 16'd0, 4'd0, 1, 1, 1);
    vecs[7]  = mkv(1, 0, 2'd0, 16'd0, 4'd0, 1, 1, 1);
    vecs[8]  = mkv(1, 0, 2'd0, 16'd0, 4'd0, 0, 1, 1);
    vecs[9]  = mkv(1, 0, 2'd0, 16'd0, 4'd0, 0, 1, 1);
    vecs[10] = mkv(1, 0, 2'd0, 16'd0, 4'd0, 0, 1, 1);
    vecs[11] = mkv(1, 0, 2'd0, 16'd0, 4'd0, 1, 1, 1);
    vecs[12] = mkv(1, 0, 2'd0, 16'd0, 4'd0, 1, 1, 1);
    vecs[13] = mkv(1, 0, 2'd0, 16'd0, 4'd0, 1, 1, 1);
    vecs[14] = mkv(1, 0, 2'd0, 16'd0, 4'd0, 0, 1, 1);
    vecs[15] = mkv(1, 0, 2'd0, 16'd0, 4'd0, 0, 1, 1);
    vecs[16] = mkv(1, 1, 2'd2, 16'd0, 4'd0, 0, 1, 1);
    vecs[17] = mkv(1, 0, 2'd0, 16'd0, 4'd0, 1, 0, 1);
    vecs[18] = mkv(1, 0, 2'd0, 16'd0, 4'd0, 1, 0, 1);
    vecs[19] = mkv(1, 0, 2'd0, 16'd0, 4'd0, 1, 0, 1);
    vecs[20] = mkv(1, 0, 2'd0, 16'd0, 4'd0, 0, 0, 1);
    vecs[21] = mkv(1, 0, 2'd0, 16'd0, 4'd0, 0, 0, 1);
    vecs[22] = mkv(1, 0, 2'd0, 16'd0, 4'd0, 0, 0, 1);
    vecs[23] = mkv(1, 0, 2'd0, 16'd0, 4'd0, 1, 1, 1);
    vecs[24] = mkv(1, 0, 2'd0, 16'd0, 4'd0, 0, 1, 1);
    vecs[25] = mkv(1, 0, 2'd0, 16'd0, 4'd0, 1, 1, 1);
    vecs[26] = mkv(0, 0, 2'd0, 16'd0, 4'd0, 0, 1, 1);
    vecs[27] = mkv(1, 0, 2'd0, 16'd0, 4'd0, 0, 1, 0);
    vecs[28] = mkv(1, 0, 2'd0, 16'd0, 4'd0, 1, 1, 1);
    vecs[29] = mkv(1, 0, 2'd0, 16'd0, 4'd0, 0, 1, 1);

    do_reset();

    // ON from IDLE, BLINK period 3, deferred BLINK period 0, enable drop.
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk($sformatf("vec%0d led", i), led, vecs[i].led);
      chk($sformatf("vec%0d ready", i), ready, vecs[i].rdy);
      chk($sformatf("vec%0d busy", i), busy, vecs[i].busy);
      chk($sformatf("vec%0d done", i), done, 1'b0);
      en     = vecs[i].en;
      valid  = vecs[i].valid;
      mode   = vecs[i].mode;
      period = vecs[i].period;
      count  = vecs[i].count;
    end

    // Deferred apply: ON written during HI of a period-5 blink; a second
    // write (mode OFF) is held on valid while pending and must be stalled.
    do_reset();
    start_cfg(2'd2, 16'd5, 4'd0);
    for (int c = 0; c < 12; c++) begin
      chk($sformatf("defer led c%0d", c), led, (c < 5) || (c >= 10));
      chk($sformatf("defer ready c%0d", c), ready, !(c >= 2 && c <= 9));
      chk($sformatf("defer busy c%0d", c), busy, 1'b1);
      if (c == 1) begin
        valid = 1'b1; mode = 2'd1; period = 16'd0;
      end else if (c >= 2 && c <= 8) begin
        valid = 1'b1; mode = 2'd0;
      end else begin
        valid = 1'b0;
      end
      @(negedge clk);
    end

    // Asynchronous reset mid-BLINK with a config pending.
    start_cfg(2'd2, 16'd5, 4'd0);
    valid = 1'b1; mode = 2'd1; period = 16'd0;
    @(negedge clk);
    valid = 1'b0;
    chk("pre-reset ready", ready, 1'b0);
    chk("pre-reset led", led, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset led", led, 1'b0);
    chk("midreset ready", ready, 1'b1);
    chk("midreset busy", busy, 1'b0);
    chk("midreset done", done, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post-reset pending dropped led", led, 1'b0);
    chk("post-reset pending dropped busy", busy, 1'b0);

    // Burst period 2 count 3, enable dropped mid-GAP then raised again.
    do_reset();
    start_cfg(2'd3, 16'd2, 4'd3);
    check_burst(2, 3, 20);
    en = 1'b0;
    @(negedge clk);
    chk("gap disable led", led, 1'b0);
    chk("gap disable busy", busy, 1'b0);
    chk("gap disable ready", ready, 1'b1);
    chk("gap disable done", done, 1'b0);
    en = 1'b1;
    @(negedge clk);
    check_burst(2, 3, 56);

    // Burst with count 0 behaves as a single blink per burst.
    do_reset();
    start_cfg(2'd3, 16'd2, 4'd0);
    check_burst(2, 0, 40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/blinky_ctrl.md
# blinky_ctrl

LED pattern sequencer for the blinky design. It owns a prescaler and a `CounterWidth`-bit blink counter, and drives one LED in solid, continuous-blink or burst patterns. A valid/ready port writes configuration into a shadow register, which is applied only at safe phase boundaries, so a pattern change never truncates a blink.

## Interface
- `CounterWidth`, 4, width of the blink counter and of `cfg_count_i`; taken from `blinky_pkg`.
- `PrescaleWidth`, 16, width of the prescaler and of `cfg_period_i`.
- `GapTicks`, 8, ticks of LED-off gap between bursts; range 1..2^CounterWidth.
- `clk_i`  in  1  clock; one clock domain only.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `enable_i`  in  1  run enable; low forces IDLE.
- `cfg_valid_i`  in  1  configuration valid.
- `cfg_ready_o`  out  1  configuration ready; `= !pending_q`.
- `cfg_mode_i`  in  2  0 OFF, 1 ON, 2 BLINK, 3 BURST.
- `cfg_period_i`  in  PrescaleWidth  clock cycles per tick; 0 is treated as 1.
- `cfg_count_i`  in  CounterWidth  blinks per burst; 0 is treated as 1.
- `led_o`  out  1  LED drive.
- `busy_o`  out  1  `state != IDLE || pending_q`.
- `burst_done_o`  out  1  one-cycle pulse at the end of each burst.

## Operation
- **Handshake and shadow register**
  - A config is accepted on `cfg_valid_i && cfg_ready_o`; mode, period and count are captured into the shadow register and `pending_q` is set.
- **Apply event**
  - Condition: `pending_q` is set and the FSM is at a boundary.
  - Boundaries: any cycle in IDLE or SOLID; a tick cycle in LO; a tick cycle in GAP.
  - Effect: active config <= shadow; `pending_q` is cleared; prescaler, blink counter and gap counter are cleared.
  - Next state is the start state of the new mode, or IDLE if `enable_i` is low.
  - Start states: OFF->IDLE, ON->SOLID, BLINK->HI, BURST->HI.
  - An apply takes priority over every normal transition in the same cycle.
- **Prescaler**
  - Runs only in HI, LO and GAP. It counts 0..P-1, where P is the effective period; `tick` is asserted when count == P-1, and the count then wraps to 0.
- **FSM states, in priority order after apply**
  - `enable_i` low: go to IDLE from any state and clear the prescaler and both counters. Active config and pending config are kept, and a pending config is still applied.
  - IDLE (`led_o`=0): if `enable_i` is high and active mode != OFF, go to the mode's start state.
  - SOLID (`led_o`=1): hold.
  - HI (`led_o`=1): on tick, go to LO.
  - LO (`led_o`=0): on tick:
    - BLINK: go to HI.
    - BURST: if blink count == N-1 (N is the effective count), clear the blink counter, pulse `burst_done_o` and go to GAP; otherwise increment the blink counter and go to HI.
  - GAP (`led_o`=0): on tick, if gap count == GapTicks-1, clear the gap counter and go to HI; otherwise increment the gap counter.
- **Outputs**
  - `led_o` is decoded from the state register and is glitch-free.
  - `burst_done_o` is registered.

## Timing
- **Reset values:** state IDLE, active mode OFF, `pending_q`=0. Outputs: `cfg_ready_o`=1, `led_o`=0, `busy_o`=0, `burst_done_o`=0. All counters are 0.
- **Config latency:** accept in cycle t, then apply at t+1 (from IDLE or SOLID), then the new `led_o` is visible at t+2.
- **Deferred apply:** in HI, LO or GAP the apply waits for the next LO or GAP tick. At most one config can be pending; `cfg_ready_o` stays low until the apply cycle, and goes high the cycle after it.
- **Phase lengths:**
  - HI and LO each last exactly P cycles.
  - A BURST cycle lasts N·2P + GapTicks·P cycles.
  - `burst_done_o` is high in the first GAP cycle of each burst.
- **Enable:** a low `enable_i` takes effect on the next edge (one-cycle latency). On re-enable, the FSM enters IDLE, then the start state one cycle later, with a fresh prescaler.
- **Asynchronous reset mid-burst:** all state returns to its reset value immediately, and the pending config is discarded.

## Test plan
- **Reset:** assert reset mid-BLINK with `pending_q`=1 -> outputs read `led_o`=0, `cfg_ready_o`=1, `busy_o`=0 within the same cycle.
- **ON from IDLE:** config mode=ON accepted at cycle 10 -> `led_o`=1 from cycle 12; `cfg_ready_o` is low only in cycle 11.
- **Continuous blink:** BLINK with period=3 -> `led_o` repeats 3 high, 3 low. With period=0, `led_o` toggles every cycle.
- **Burst:** BURST with period=2, count=3, GapTicks=8 -> 3×(2 high, 2 low), `burst_done_o` pulsed once, 16 cycles low; 28-cycle repeat. With count=0 the pattern is a single blink per burst.
- **Deferred config:** write ON during a BLINK HI phase with period=5 -> `led_o` finishes the full HI phase and the LO phase, the apply happens on the LO tick, and `led_o`=1 one cycle later. A second `cfg_valid_i` in the meantime is stalled (`cfg_ready_o`=0).
- **Enable toggling:** drop `enable_i` mid-GAP -> IDLE next cycle with `led_o`=0. Raise it again -> HI after two cycles with the blink counter at 0.
